// File: rtl/seq_compare_unit.sv
// Purpose: multi-cycle WIDTH-bit comparator, CHUNK bits per cycle, MSB chunk first, early exit on first difference.
// Latency: k+1 cycles from presenting an accepted pair to out_valid, k = chunks scanned (1..NCHUNK).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no accept on the handoff edge.
module seq_compare_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_neq,
    output logic             out_lt,
    output logic             out_ltu,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // Flipping the sign bit turns a signed compare of the top chunk into an unsigned one.
    localparam logic [CHUNK-1:0] SIGN_MASK = CHUNK'(1) << (CHUNK - 1);

    localparam logic [1:0] OP_EQ  = 2'b00;
    localparam logic [1:0] OP_NE  = 2'b01;
    localparam logic [1:0] OP_LT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [1:0]        r_op;
    logic [IDXW-1:0]   r_idx;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_out_valid;
    logic              r_taken;
    logic              r_neq;
    logic              r_lt;
    logic              r_ltu;

    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic              w_last;
    logic              w_neq;
    logic              w_ltu;
    logic              w_lt;
    logic              w_taken;

    // Select the chunk currently under comparison.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    assign w_last = (r_idx == IDXW'(NCHUNK - 1));
    assign w_neq  = (w_a_chunk != w_b_chunk);
    assign w_ltu  = (w_a_chunk < w_b_chunk);
    // Only the most significant chunk carries the sign; lower chunks order unsigned.
    assign w_lt   = w_last ? ((w_a_chunk ^ SIGN_MASK) < (w_b_chunk ^ SIGN_MASK)) : w_ltu;

    // Branch condition for a differing chunk, selected by the captured op.
    always_comb begin
        w_taken = 1'b0;
        case (r_op)
            OP_EQ:   w_taken = 1'b0;
            OP_NE:   w_taken = 1'b1;
            OP_LT:   w_taken = w_lt;
            default: w_taken = w_ltu;
        endcase
    end

    // Control FSM: capture, chunk scan, and result hold with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_neq       <= 1'b0;
            r_lt        <= 1'b0;
            r_ltu       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= op_a;
                        r_b        <= op_b;
                        r_op       <= op_sel;
                        r_idx      <= IDXW'(NCHUNK - 1);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_neq) begin
                        r_neq       <= 1'b1;
                        r_lt        <= w_lt;
                        r_ltu       <= w_ltu;
                        r_taken     <= w_taken;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_idx == '0) begin
                        // Every chunk matched: operands are equal.
                        r_neq       <= 1'b0;
                        r_lt        <= 1'b0;
                        r_ltu       <= 1'b0;
                        r_taken     <= (r_op == OP_EQ);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_taken = r_taken;
    assign out_neq   = r_neq;
    assign out_lt    = r_lt;
    assign out_ltu   = r_ltu;

endmodule

// File: tb/tb_seq_compare_unit.sv
// Bench for seq_compare_unit: directed scenarios then randomized operand pairs,
// checked against an arithmetic reference model (signed/unsigned compare, latency from first differing bit).
// Latency is counted in clock edges starting with the edge that accepts the request.
module tb_seq_compare_unit;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_sel;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_neq;
    logic             out_lt;
    logic             out_ltu;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    seq_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_taken (out_taken),
        .out_neq   (out_neq),
        .out_lt    (out_lt),
        .out_ltu   (out_ltu),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: chunks scanned = chunks from the top down to the one holding the highest differing bit.
    function automatic int model_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        int top;
        x   = a ^ b;
        top = -1;
        for (int p = 0; p < WIDTH; p++) if (x[p]) top = p;
        if (top < 0) return NCHUNK + 1;
        return (NCHUNK - top / CHUNK) + 1;
    endfunction

    function automatic logic model_taken(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic [1:0] op);
        case (op)
            2'd0:    return a == b;
            2'd1:    return a != b;
            2'd2:    return $signed(a) < $signed(b);
            default: return a < b;
        endcase
    endfunction

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op);
        op_a     = a;
        op_b     = b;
        op_sel   = op;
        in_valid = 1'b1;
    endtask

    task automatic check_flags(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [1:0] op);
        chkb({tag, ".taken"}, out_taken, model_taken(a, b, op));
        chkb({tag, ".neq"},   out_neq,   a != b);
        chkb({tag, ".lt"},    out_lt,    $signed(a) < $signed(b));
        chkb({tag, ".ltu"},   out_ltu,   a < b);
    endtask

    // Waits (bounded) for out_valid; request must already be presented.
    task automatic wait_result(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [1:0] op);
        int  cyc;
        bit  got;
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clock);
            #1;
            cyc++;
            in_valid = 1'b0;
            if (out_valid === 1'b1) got = 1'b1;
        end
        chkb({tag, ".seen"}, got, 1'b1);
        if (got) begin
            chk({tag, ".latency"}, cyc, model_latency(a, b));
            check_flags(tag, a, b, op);
            chkb({tag, ".in_ready"}, in_ready, 1'b0);
            chkb({tag, ".busy"}, busy, 1'b1);
        end
    endtask

    // Keep result stalled while poking in_valid; everything must stay put.
    task automatic hold_done(input string tag, input int n, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [1:0] op);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            op_a     = $urandom;
            op_b     = $urandom;
            @(posedge clock);
            #1;
            chkb({tag, ".hold_valid"}, out_valid, 1'b1);
            chkb({tag, ".hold_in_ready"}, in_ready, 1'b0);
            check_flags({tag, ".hold"}, a, b, op);
        end
        in_valid = 1'b0;
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chkb({tag, ".post_valid"}, out_valid, 1'b0);
        chkb({tag, ".post_in_ready"}, in_ready, 1'b1);
        chkb({tag, ".post_busy"}, busy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [1:0] op);
        start_op(a, b, op);
        wait_result(tag, a, b, op);
        handoff(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [1:0]       rop;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sel    = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chkb("rst.in_ready", in_ready, 1'b1);
        chkb("rst.out_valid", out_valid, 1'b0);
        chkb("rst.busy", busy, 1'b0);
        chkb("rst.taken", out_taken, 1'b0);
        chkb("rst.neq", out_neq, 1'b0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Equal operands, full scan
        run_op("eq_full", 32'h12345678, 32'h12345678, 2'd0);

        // Top chunk differs, signed vs unsigned
        run_op("lt_top", 32'h80000000, 32'h00000001, 2'd2);
        run_op("ltu_top", 32'h80000000, 32'h00000001, 2'd3);

        // Difference only in lowest chunk
        run_op("ne_low", 32'h000000FF, 32'h000000FE, 2'd1);

        // Stalled result with ignored in_valid pulses
        start_op(32'h00ABCDEF, 32'h00ABCD00, 2'd3);
        wait_result("stall", 32'h00ABCDEF, 32'h00ABCD00, 2'd3);
        hold_done("stall", 10, 32'h00ABCDEF, 32'h00ABCD00, 2'd3);
        handoff("stall");

        // Reset mid-scan discards the in-flight result
        start_op(32'hCAFEBABE, 32'hCAFEBABE, 2'd0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        chkb("midrst.in_ready", in_ready, 1'b1);
        chkb("midrst.out_valid", out_valid, 1'b0);
        chkb("midrst.busy", busy, 1'b0);
        chkb("midrst.neq", out_neq, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            chkb("midrst.no_result", out_valid, 1'b0);
        end

        // Back-to-back: next request presented during the handoff edge must wait
        start_op(32'hFFFFFFFF, 32'h7FFFFFFF, 2'd2);
        wait_result("b2b_lt", 32'hFFFFFFFF, 32'h7FFFFFFF, 2'd2);
        start_op(32'hFFFFFFFF, 32'h7FFFFFFF, 2'd3);
        handoff("b2b_lt");
        wait_result("b2b_ltu", 32'hFFFFFFFF, 32'h7FFFFFFF, 2'd3);
        handoff("b2b_ltu");

        // Randomized pairs; b shares a random subset of chunks with a
        for (int n = 0; n < 60; n++) begin
            ra  = $urandom;
            rb  = ra;
            rop = 2'($urandom_range(0, 3));
            for (int c = 0; c < NCHUNK; c++)
                if ($urandom_range(0, 3) == 0) rb[c*CHUNK +: CHUNK] = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rb = $urandom;
            start_op(ra, rb, rop);
            wait_result("rand", ra, rb, rop);
            if ($urandom_range(0, 2) == 0) hold_done("rand", $urandom_range(1, 3), ra, rb, rop);
            handoff("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
